uart_tx_frame: RTL

Parametrised UART transmitter with an internal baud-tick generator. Runs entirely on the system clock; no derived clocks, no ripple clocking. Serialises one character per valid/ready handshake. Frame format is configurable in data bits, parity and stop bits. Sits between any byte producer (counters, keypad logic, soft-core peripherals) and the FTDI TX pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx_frame.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity modes, FSM encoding and
// the baud divisor helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1, pulses bit_end on the last count and
// can be forced back to 0 so a new frame starts on a full bit period.
module uart_baud_gen #(
  parameter int DIV = 16
) (
  input  logic hwclk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg + CW'(1);
    if (restart || cnt_reg == LAST) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign bit_end = (cnt_reg == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable data/parity/stop format and internal baud
// timing. Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of it.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 hwclk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int BW  = $clog2(DATA_BITS);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_frame: CLK_HZ/BAUD gives a divisor below 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  state_t               state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [BW-1:0]        bit_idx_reg, bit_idx_next;
  logic                 stop_idx_reg, stop_idx_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg, tx_next;
  logic                 rdy_en_reg;
  logic                 bit_end, restart, frame_end, ser_ready, load;
  logic [DATA_BITS-1:0] load_data;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .hwclk   (hwclk),
    .rst_n   (rst_n),
    .restart (restart),
    .bit_end (bit_end)
  );

  assign frame_end = (state_reg == ST_STOP) && bit_end &&
                     (stop_idx_reg == 1'(STOP_BITS - 1));
  // rdy_en_reg keeps ready low until the first clock after reset release.
  assign ser_ready = rdy_en_reg && ((state_reg == ST_IDLE) || frame_end);
  assign tx_done   = frame_end;
  assign tx        = tx_reg;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_frame: FIFO_DEPTH must be a power of 2, at least 2");
  end

  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] fifo_head_reg;
  logic [AW:0]          wr_ptr_reg, rd_ptr_reg;
  logic [AW-1:0]        rd_addr_next;
  logic                 fifo_empty, fifo_full, push, pop;

  assign fifo_empty   = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign tx_ready     = rdy_en_reg && !fifo_full;
  assign push         = tx_valid && tx_ready;
  assign pop          = ser_ready && !fifo_empty;
  assign rd_addr_next = rd_ptr_reg[AW-1:0] + AW'(pop);
  assign load         = pop;
  assign load_data    = fifo_head_reg;
  assign busy         = (state_reg != ST_IDLE) || !fifo_empty;

  // Registered read of the next head; a write to that slot is bypassed so an
  // empty FIFO presents the new character one cycle after the push.
  always_ff @(posedge hwclk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= tx_data;
    end
    if (push && wr_ptr_reg[AW-1:0] == rd_addr_next) begin
      fifo_head_reg <= tx_data;
    end else begin
      fifo_head_reg <= fifo_mem[rd_addr_next];
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end
`else
  // FIFO_DEPTH has no effect without the FIFO.
  if (FIFO_DEPTH < 0) begin : g_fifo_depth_unused
  end

  assign tx_ready  = ser_ready;
  assign load      = tx_valid && ser_ready;
  assign load_data = tx_data;
  assign busy      = (state_reg != ST_IDLE);
`endif

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    stop_idx_next = stop_idx_reg;
    parity_next   = parity_reg;
    restart       = 1'b0;
    if (load) begin
      state_next    = ST_START;
      shift_next    = load_data;
      bit_idx_next  = '0;
      stop_idx_next = 1'b0;
      parity_next   = (^load_data) ^ (PARITY == PARITY_ODD);
      restart       = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_IDLE;
        ST_START: begin
          if (bit_end) state_next = ST_DATA;
        end
        ST_DATA: begin
          if (bit_end) begin
            shift_next = shift_reg >> 1;
            if (bit_idx_reg == BW'(DATA_BITS - 1)) begin
              bit_idx_next = '0;
              state_next   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_next = bit_idx_reg + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) state_next = ST_STOP;
        end
        ST_STOP: begin
          if (frame_end) begin
            state_next = ST_IDLE;
          end else if (bit_end) begin
            stop_idx_next = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // The line level is derived from the next state so tx comes straight from a flop.
  always_comb begin
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = parity_next;
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      rdy_en_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      stop_idx_reg <= stop_idx_next;
      parity_reg   <= parity_next;
      tx_reg       <= tx_next;
      rdy_en_reg   <= 1'b1;
    end
  end

endmodule
